// File: rtl/regfile.sv
// regfile: 31x64-bit register file with hardwired-zero index 31, two combinational read ports and write-first bypass
module regfile #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         RegWrite,
  input  logic [4:0]   WriteRegister,
  input  logic [N-1:0] WriteData,
  input  logic [4:0]   ReadRegister1,
  input  logic [4:0]   ReadRegister2,
  output logic [N-1:0] ReadData1,
  output logic [N-1:0] ReadData2
);
  logic [N-1:0] regs [0:30];
  logic [30:0]  wr_en;
  logic         wr_live;
  logic         byp1;
  logic         byp2;
  logic [N-1:0] stored1;
  logic [N-1:0] stored2;
  // index 31 shifts the one out of the 31-bit field, so XZR writes enable nothing
  assign wr_en = {31{RegWrite}} & (31'd1 << WriteRegister);
  for (genvar i = 0; i < 31; i++) begin : g_reg
    always_ff @(posedge clk) begin
      if (reset) regs[i] <= '0;
      else if (wr_en[i]) regs[i] <= WriteData;
    end
  end
  assign wr_live  = RegWrite && !reset && (WriteRegister != 5'd31);
  assign byp1     = wr_live && (ReadRegister1 == WriteRegister);
  assign byp2     = wr_live && (ReadRegister2 == WriteRegister);
  assign stored1  = (ReadRegister1 == 5'd31) ? '0 : regs[ReadRegister1];
  assign stored2  = (ReadRegister2 == 5'd31) ? '0 : regs[ReadRegister2];
  assign ReadData1 = byp1 ? WriteData : stored1;
  assign ReadData2 = byp2 ? WriteData : stored2;
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed scenario tasks plus random traffic against a reference array for regfile
module tb_regfile;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        RegWrite = 1'b0;
  logic [4:0]  WriteRegister = '0;
  logic [63:0] WriteData = '0;
  logic [4:0]  ReadRegister1 = '0;
  logic [4:0]  ReadRegister2 = '0;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;
  int errors = 0;
  int checks = 0;
  logic [63:0] model [0:31];

  regfile #(.N(64)) dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2)
  );

  always #5 clk = ~clk;

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; RegWrite = 1'b0;
    edge_step();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i); ReadRegister2 = 5'(31 - i);
      @(negedge clk);
      checks++;
      if (ReadData1 !== 64'd0 || ReadData2 !== 64'd0) begin
        errors++;
        $display("FAIL reset_sweep idx %0d: rd1=%h rd2=%h expected 0", i, ReadData1, ReadData2);
      end
    end
  endtask

  task automatic test_write_read();
    RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 64'hDEADBEEF_CAFEF00D;
    edge_step();
    RegWrite = 1'b0; ReadRegister1 = 5'd5; ReadRegister2 = 5'd5;
    @(negedge clk);
    checks++;
    if (ReadData1 !== 64'hDEADBEEF_CAFEF00D || ReadData2 !== 64'hDEADBEEF_CAFEF00D) begin
      errors++;
      $display("FAIL write_read_x5: rd1=%h rd2=%h expected deadbeefcafef00d", ReadData1, ReadData2);
    end
    ReadRegister1 = 5'd4; ReadRegister2 = 5'd6;
    @(negedge clk);
    checks++;
    if (ReadData1 !== 64'd0 || ReadData2 !== 64'd0) begin
      errors++;
      $display("FAIL neighbours_x4_x6: rd1=%h rd2=%h expected 0", ReadData1, ReadData2);
    end
  endtask

  task automatic test_xzr();
    RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 64'hFFFF_FFFF_FFFF_FFFF;
    ReadRegister1 = 5'd31; ReadRegister2 = 5'd5;
    @(negedge clk);
    checks++;
    if (ReadData1 !== 64'd0) begin
      errors++;
      $display("FAIL xzr_same_cycle: rd1=%h expected 0", ReadData1);
    end
    edge_step();
    RegWrite = 1'b0;
    @(negedge clk);
    checks++;
    if (ReadData1 !== 64'd0) begin
      errors++;
      $display("FAIL xzr_after_edge: rd1=%h expected 0", ReadData1);
    end
    checks++;
    if (ReadData2 !== 64'hDEADBEEF_CAFEF00D) begin
      errors++;
      $display("FAIL xzr_no_alias_x5: rd2=%h expected deadbeefcafef00d", ReadData2);
    end
  endtask

  task automatic test_bypass();
    RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'h1111;
    edge_step();
    WriteRegister = 5'd8; WriteData = 64'h8888;
    edge_step();
    WriteRegister = 5'd7; WriteData = 64'h2222; ReadRegister1 = 5'd7; ReadRegister2 = 5'd8;
    @(negedge clk);
    checks++;
    if (ReadData1 !== 64'h2222) begin
      errors++;
      $display("FAIL bypass_rd1: rd1=%h expected 2222", ReadData1);
    end
    checks++;
    if (ReadData2 !== 64'h8888) begin
      errors++;
      $display("FAIL bypass_rd2_stored: rd2=%h expected 8888", ReadData2);
    end
    ReadRegister2 = 5'd7;
    @(negedge clk);
    checks++;
    if (ReadData1 !== 64'h2222 || ReadData2 !== 64'h2222) begin
      errors++;
      $display("FAIL bypass_same_index: rd1=%h rd2=%h expected 2222", ReadData1, ReadData2);
    end
    edge_step();
    RegWrite = 1'b0;
    @(negedge clk);
    checks++;
    if (ReadData1 !== 64'h2222) begin
      errors++;
      $display("FAIL bypass_after_edge: rd1=%h expected 2222", ReadData1);
    end
  endtask

  task automatic test_no_write();
    RegWrite = 1'b0; WriteRegister = 5'd7; WriteData = 64'hBAD0;
    edge_step();
    ReadRegister1 = 5'd7;
    @(negedge clk);
    checks++;
    if (ReadData1 !== 64'h2222) begin
      errors++;
      $display("FAIL write_disabled: rd1=%h expected 2222", ReadData1);
    end
  endtask

  task automatic test_reset_vs_write();
    RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'h33;
    edge_step();
    reset = 1'b1; WriteData = 64'h55; ReadRegister1 = 5'd3; ReadRegister2 = 5'd5;
    @(negedge clk);
    checks++;
    if (ReadData1 !== 64'h33) begin
      errors++;
      $display("FAIL reset_bypass_suppressed: rd1=%h expected 33", ReadData1);
    end
    edge_step();
    @(negedge clk);
    checks++;
    if (ReadData1 !== 64'd0 || ReadData2 !== 64'd0) begin
      errors++;
      $display("FAIL reset_beats_write: rd1=%h rd2=%h expected 0", ReadData1, ReadData2);
    end
    reset = 1'b0; RegWrite = 1'b0;
    @(negedge clk);
    checks++;
    if (ReadData1 !== 64'd0) begin
      errors++;
      $display("FAIL reset_x3_cleared: rd1=%h expected 0", ReadData1);
    end
    RegWrite = 1'b1; WriteData = 64'h77;
    edge_step();
    RegWrite = 1'b0;
    @(negedge clk);
    checks++;
    if (ReadData1 !== 64'h77) begin
      errors++;
      $display("FAIL write_after_reset: rd1=%h expected 77", ReadData1);
    end
  endtask

  task automatic test_back_to_back();
    RegWrite = 1'b1; WriteRegister = 5'd10; WriteData = 64'hA1;
    edge_step();
    WriteRegister = 5'd11; WriteData = 64'hB1;
    edge_step();
    WriteRegister = 5'd10; WriteData = 64'hA2; ReadRegister1 = 5'd11; ReadRegister2 = 5'd12;
    @(negedge clk);
    checks++;
    if (ReadData1 !== 64'hB1) begin
      errors++;
      $display("FAIL b2b_x11: rd1=%h expected b1", ReadData1);
    end
    edge_step();
    WriteData = 64'hA3;
    edge_step();
    RegWrite = 1'b0; ReadRegister1 = 5'd10;
    @(negedge clk);
    checks++;
    if (ReadData1 !== 64'hA3) begin
      errors++;
      $display("FAIL b2b_last_wins: rd1=%h expected a3", ReadData1);
    end
  endtask

  task automatic test_random();
    logic [63:0] exp1, exp2;
    bit live;
    reset = 1'b1; RegWrite = 1'b0;
    edge_step();
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int n = 0; n < 10000; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      RegWrite = 1'($urandom_range(0, 1));
      WriteRegister = 5'($urandom_range(0, 31));
      WriteData = {$urandom, $urandom};
      ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
      ReadRegister2 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
      @(negedge clk);
      live = RegWrite && !reset && WriteRegister != 5'd31;
      exp1 = (live && ReadRegister1 == WriteRegister) ? WriteData : model[ReadRegister1];
      exp2 = (live && ReadRegister2 == WriteRegister) ? WriteData : model[ReadRegister2];
      checks++;
      if (ReadData1 !== exp1) begin
        errors++;
        if (errors < 20) $display("FAIL random_rd1 cycle %0d idx %0d: got %h expected %h", n, ReadRegister1, ReadData1, exp1);
      end
      checks++;
      if (ReadData2 !== exp2) begin
        errors++;
        if (errors < 20) $display("FAIL random_rd2 cycle %0d idx %0d: got %h expected %h", n, ReadRegister2, ReadData2, exp2);
      end
      @(posedge clk);
      if (reset) for (int i = 0; i < 32; i++) model[i] = '0;
      else if (live) model[WriteRegister] = WriteData;
      #1;
    end
    reset = 1'b0; RegWrite = 1'b0;
  endtask

  initial begin
    edge_step();
    test_reset();
    test_write_read();
    test_xzr();
    test_bypass();
    test_no_write();
    test_reset_vs_write();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
